// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ifu_pkg;

    // Responder states: IDLE (no fetch), WAIT (request outstanding),
    // DROP (flushed request still outstanding), HOLD (instruction presented).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    // Byte span covered by an instruction memory of the given word depth.
    function automatic logic [31:0] word_span(input int words);
        return 32'(words) * 32'd4;
    endfunction

endpackage

// File: rtl/ifu_addr_check.sv
// Maps a fetch byte address to a word index and flags misaligned/out-of-range addresses.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports: addr (byte address in), idx (word index, wraps modulo IM_WORDS), bad (address error).
// ALIGN_CHECK / RANGE_CHECK = 0 disables the corresponding part of 'bad'.
module ifu_addr_check
    import ifu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_PC,
    parameter int          IM_WORDS    = 1024,
    parameter int          AW          = $clog2(IM_WORDS),
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter bit          RANGE_CHECK = 1'b1
) (
    input  logic [31:0]   addr,
    output logic [AW-1:0] idx,
    output logic          bad
);

    logic [31:0] offset;

    // Modulo-2^32 offset from the base; an address below the base wraps to a
    // huge offset, so a single unsigned compare covers both range limits.
    assign offset = addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign bad    = (ALIGN_CHECK && (addr[1:0] != 2'b00)) ||
                    (RANGE_CHECK && (offset >= word_span(IM_WORDS)));

endmodule

// File: rtl/ifu_fetch_responder.sv
// Fetch responder: turns PC fetch addresses into instruction-memory req/ack reads and presents Instr/InstrPc to IF/ID.
// Latency: 2 cycles minimum from accept to InstrValid (ack in first MemReq cycle); one fetch in flight at a time.
// Backpressure: Stall (combinational) holds the PC while a fetch is outstanding or the presented word is not taken.
//
// Ports: Clk/Reset (async active-low); Addr/ReqValid from PC; Stall to PC (En = ~Stall); Flush redirect;
// MemReq/MemAddr/MemAck/MemData instruction-memory handshake; Instr/InstrPc/InstrValid/InstrReady/AdelExc to IF/ID.
// Build macro ADDR_CHECK_EN: when defined, misaligned/out-of-range addresses skip memory and return a nop with AdelExc=1.
module ifu_fetch_responder
    import ifu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter int          IM_WORDS  = 1024,
    parameter int          AW        = $clog2(IM_WORDS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [31:0]   Addr,
    input  logic          ReqValid,
    output logic          Stall,
    input  logic          Flush,
    output logic          MemReq,
    output logic [AW-1:0] MemAddr,
    input  logic          MemAck,
    input  logic [31:0]   MemData,
    output logic [31:0]   Instr,
    output logic [31:0]   InstrPc,
    output logic          InstrValid,
    input  logic          InstrReady,
    output logic          AdelExc
);

`ifdef ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    ifu_state_e    state;
    logic [31:0]   pc_q;
    logic [AW-1:0] idx;
    logic          bad;
    logic          acc;

    // With checking disabled 'bad' is tied low, so the error path folds away.
    ifu_addr_check #(
        .BASE_ADDR  (BASE_ADDR),
        .IM_WORDS   (IM_WORDS),
        .AW         (AW),
        .ALIGN_CHECK(CHECK_EN),
        .RANGE_CHECK(CHECK_EN)
    ) u_addr_check (
        .addr(Addr),
        .idx (idx),
        .bad (bad)
    );

    // A new address is taken only when idle or when the presented word leaves
    // this cycle; never during a Flush, since the PC is loading the redirect.
    assign acc   = ReqValid && !Flush &&
                   ((state == IDLE) || ((state == HOLD) && InstrReady));
    assign Stall = !Flush &&
                   ((state == WAIT) || (state == DROP) || ((state == HOLD) && !InstrReady));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            pc_q       <= BASE_ADDR;
            MemReq     <= 1'b0;
            MemAddr    <= '0;
            Instr      <= NOP_INSTR;
            InstrPc    <= BASE_ADDR;
            InstrValid <= 1'b0;
            AdelExc    <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                WAIT: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        if (Flush) begin
                            // Data arriving with a redirect is stale; drop it.
                            state <= IDLE;
                        end else begin
                            Instr      <= MemData;
                            InstrPc    <= pc_q;
                            AdelExc    <= 1'b0;
                            InstrValid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (Flush) begin
                        // Memory still owes an ack; keep MemReq up and swallow it.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                HOLD: begin
                    // Flush wins over InstrReady: the word is withdrawn either way.
                    if (Flush || InstrReady) begin
                        InstrValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase

            // Accept overrides the HOLD->IDLE move above for back-to-back fetches.
            if (acc) begin
                pc_q <= Addr;
                if (bad) begin
                    Instr      <= NOP_INSTR;
                    InstrPc    <= Addr;
                    AdelExc    <= 1'b1;
                    InstrValid <= 1'b1;
                    state      <= HOLD;
                end else begin
                    MemReq  <= 1'b1;
                    MemAddr <= idx;
                    state   <= WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Randomised bench for ifu_fetch_responder with a transaction-level reference model and scoreboard.
// Latency: n/a (testbench).
// Backpressure: InstrReady and memory ack latency are randomised.
module tb_ifu_fetch_responder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          WORDS = 1024;
`ifdef ADDR_CHECK_EN
    localparam bit CHECKS_ON = 1'b1;
`else
    localparam bit CHECKS_ON = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [31:0] Addr;
    logic        ReqValid;
    logic        Stall;
    logic        Flush;
    logic        MemReq;
    logic [9:0]  MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic        InstrValid;
    logic        InstrReady;
    logic        AdelExc;

    ifu_fetch_responder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Addr      (Addr),
        .ReqValid  (ReqValid),
        .Stall     (Stall),
        .Flush     (Flush),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemAck    (MemAck),
        .MemData   (MemData),
        .Instr     (Instr),
        .InstrPc   (InstrPc),
        .InstrValid(InstrValid),
        .InstrReady(InstrReady),
        .AdelExc   (AdelExc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [31:0] mem_word(input logic [9:0] i);
        return 32'h3C01_0001 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    function automatic logic [9:0] ref_idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return 10'((d / 4) % WORDS);
    endfunction

    function automatic bit ref_bad(input logic [31:0] a);
        return CHECKS_ON && ((a % 4 != 0) || (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * WORDS)));
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // ---------------- knobs ----------------
    int rv_pct  = 100;
    int rdy_pct = 100;
    int fl_pct  = 0;
    int lat_lo  = 1;
    int lat_hi  = 1;
    bit mem_force = 1'b0;
    bit redir_req = 1'b0;
    logic [31:0] redir_tgt = BASE;

    // ---------------- instruction memory responder ----------------
    int mem_cnt = 0;
    always begin
        @(negedge Clk);
        if (!Reset) begin
            MemAck  = 1'b0;
            mem_cnt = $urandom_range(lat_hi, lat_lo);
        end else if (mem_force) begin
            MemAck  = 1'b1;
            MemData = 32'hDEAD_BEEF;
        end else if (MemAck) begin
            MemAck  = 1'b0;
            MemData = $urandom;
            mem_cnt = $urandom_range(lat_hi, lat_lo);
        end else if (MemReq) begin
            if (mem_cnt == 0) begin
                MemAck  = 1'b1;
                MemData = mem_word(MemAddr);
            end else begin
                mem_cnt--;
            end
        end
    end

    // ---------------- scoreboard + model + monitor ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t       sb[$];
    bit         m_busy  = 1'b0;   // accepted fetch not yet delivered or flushed
    bit         m_ready = 1'b0;   // its data is available (being presented)
    bit         m_drop  = 1'b0;   // flushed memory read still owed an ack
    logic [9:0] m_idx   = '0;
    bit         last_acc = 1'b0;
    int         n_deliv = 0;

    always begin
        bit   exp_valid, exp_memreq, exp_stall, ack, acc, bad;
        exp_t e;
        @(negedge Clk);
        #2;
        if (!Reset) begin
            m_busy   = 1'b0;
            m_ready  = 1'b0;
            m_drop   = 1'b0;
            last_acc = 1'b0;
            sb.delete();
        end else begin
            exp_valid  = m_busy && m_ready;
            exp_memreq = (m_busy && !m_ready) || m_drop;
            exp_stall  = !Flush && (m_drop || (m_busy && !(exp_valid && InstrReady)));
            chk("InstrValid", 32'(InstrValid), 32'(exp_valid));
            if (exp_valid && sb.size() > 0) begin
                chk("Instr", Instr, sb[0].instr);
                chk("InstrPc", InstrPc, sb[0].pc);
                chk("AdelExc", 32'(AdelExc), 32'(sb[0].adel));
            end
            chk("MemReq", 32'(MemReq), 32'(exp_memreq));
            if (exp_memreq) chk("MemAddr", 32'(MemAddr), 32'(m_idx));
            chk("Stall", 32'(Stall), 32'(exp_stall));

            // Predict what the coming rising edge does.
            ack = MemAck && exp_memreq;
            acc = ReqValid && !Flush && ((!m_busy && !m_drop) || (exp_valid && InstrReady));
            if (exp_valid && InstrReady && !Flush) begin
                void'(sb.pop_front());
                m_busy = 1'b0;
                n_deliv++;
            end
            if (m_drop && ack) m_drop = 1'b0;
            if (Flush && m_busy) begin
                if (!m_ready && !ack) m_drop = 1'b1;
                m_busy = 1'b0;
                sb.delete();
            end
            if (m_busy && !m_ready && ack) m_ready = 1'b1;
            if (acc) begin
                bad     = ref_bad(Addr);
                e.pc    = Addr;
                e.instr = bad ? 32'h0 : mem_word(ref_idx(Addr));
                e.adel  = bad;
                sb.push_back(e);
                m_busy  = 1'b1;
                m_ready = bad;
                m_idx   = ref_idx(Addr);
            end
            last_acc = acc;
        end
    end

    // ---------------- stimulus: a PC that advances on each accepted fetch ----------------
    bit          prev_flush = 1'b0;
    logic [31:0] tgt = BASE;

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      return BASE + 32'(4 * $urandom_range(0, 1100));
        else if (r < 8) return BASE + 32'($urandom_range(0, 4095));
        else            return $urandom;
    endfunction

    task automatic step();
        @(negedge Clk);
        if (prev_flush)    Addr = tgt;
        else if (last_acc) Addr = Addr + 32'd4;
        ReqValid   = pct(rv_pct);
        InstrReady = pct(rdy_pct);
        if (redir_req) begin
            Flush     = 1'b1;
            tgt       = redir_tgt;
            redir_req = 1'b0;
        end else if (pct(fl_pct)) begin
            Flush = 1'b1;
            tgt   = rand_target();
        end else begin
            Flush = 1'b0;
        end
        prev_flush = Flush;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_MemReq"}, 32'(MemReq), 32'h0);
        chk({tag, "_MemAddr"}, 32'(MemAddr), 32'h0);
        chk({tag, "_InstrValid"}, 32'(InstrValid), 32'h0);
        chk({tag, "_Instr"}, Instr, 32'h0);
        chk({tag, "_InstrPc"}, InstrPc, BASE);
        chk({tag, "_AdelExc"}, 32'(AdelExc), 32'h0);
        chk({tag, "_Stall"}, 32'(Stall), 32'h0);
    endtask

    initial begin
        bit found;
        Reset      = 1'b0;
        Addr       = BASE;
        ReqValid   = 1'b0;
        Flush      = 1'b0;
        InstrReady = 1'b1;
        MemAck     = 1'b0;
        MemData    = '0;
        repeat (3) @(negedge Clk);
        #3;
        check_reset_vals("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // First fetch from the base, ack one cycle after MemReq.
        rv_pct = 100; rdy_pct = 100; fl_pct = 0; lat_lo = 1; lat_hi = 1;
        run(8);

        // Back-to-back sequential fetches, ack latency 3.
        lat_lo = 3; lat_hi = 3;
        run(40);

        // Heavy backpressure from IF/ID.
        rdy_pct = 20; lat_lo = 0; lat_hi = 2;
        run(80);

        // Directed redirect to 0x3040 then flush-heavy traffic.
        rdy_pct = 100; lat_lo = 2; lat_hi = 2;
        run(3);
        redir_tgt = 32'h0000_3040; redir_req = 1'b1;
        run(20);
        fl_pct = 12; lat_lo = 0; lat_hi = 3; rdy_pct = 60;
        run(300);

        // Long mixed random run.
        rv_pct = 85; rdy_pct = 70; fl_pct = 6;
        run(3000);

        // Reset asserted while a request is outstanding; then a late ack.
        rv_pct = 100; rdy_pct = 100; fl_pct = 0; lat_lo = 5; lat_hi = 5;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            #3;
            if (m_busy && !m_ready && !m_drop) found = 1'b1;
        end
        chk("reset_wait_reached", 32'(found), 32'h1);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        @(negedge Clk);
        #3;
        check_reset_vals("midreset");
        @(negedge Clk);
        Reset      = 1'b1;
        ReqValid   = 1'b0;
        prev_flush = 1'b0;
        rv_pct     = 0;
        @(posedge Clk);
        mem_force = 1'b1;
        @(posedge Clk);
        mem_force = 1'b0;
        run(4);
        #3;
        chk("late_ack_InstrValid", 32'(InstrValid), 32'h0);
        chk("late_ack_InstrPc", InstrPc, BASE);

        // Redirect to a misaligned address (address error when checking is built in).
        rv_pct = 100; lat_lo = 1; lat_hi = 1;
        run(2);
        redir_tgt = 32'h0000_3002; redir_req = 1'b1;
        run(12);

        run(5);
        chk("deliveries_seen", 32'(n_deliv > 200), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
